// File: rtl/fxp4s_pkg.sv
// Shared fxp4s constants, FSM state encoding and sign-magnitude pack/unpack helpers.
// Used by both the multiply and divide paths.
package fxp4s_pkg;

  localparam int FXP4S_WIDTH = 4;
  localparam int FXP4S_SIGN  = FXP4S_WIDTH - 1;
  localparam int FXP4S_MAG   = FXP4S_WIDTH - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fxp4s_state_e;

  function automatic logic fxp4s_sign(input logic [FXP4S_WIDTH-1:0] v);
    return v[FXP4S_SIGN];
  endfunction

  function automatic logic [FXP4S_MAG-1:0] fxp4s_mag(input logic [FXP4S_WIDTH-1:0] v);
    return v[FXP4S_MAG-1:0];
  endfunction

  // A zero magnitude never carries a sign bit.
  function automatic logic [FXP4S_WIDTH-1:0] fxp4s_pack(input logic s,
                                                         input logic [FXP4S_MAG-1:0] m);
    return {s & (m != '0), m};
  endfunction

endpackage

// File: rtl/fxp4s_mul_step.sv
// One shift-add partial product: adds a_mag<<cnt into acc when the selected multiplier bit is set.
// Purely combinational, no handshake.
module fxp4s_mul_step
  import fxp4s_pkg::*;
#(
  parameter int MAG = FXP4S_MAG,
  parameter int CW  = 2
) (
  input  logic [2*MAG-1:0] acc,
  input  logic [MAG-1:0]   a_mag,
  input  logic             b_bit,
  input  logic [CW-1:0]    cnt,
  output logic [2*MAG-1:0] acc_nxt
);

  logic [2*MAG-1:0] a_ext;
  logic [2*MAG-1:0] pp;

  always_comb begin
    a_ext   = {{MAG{1'b0}}, a_mag};
    pp      = a_ext << cnt;
    acc_nxt = b_bit ? (acc + pp) : acc;
  end

endmodule

// File: rtl/fxp4s_mul_seq.sv
// Sequential sign-magnitude multiplier: result valid the cycle after MAG run edges; holds in DONE until out_ready.
// in_ready only in IDLE; FXP4S_MUL_SAT_EN selects saturation instead of wrap on overflow.
module fxp4s_mul_seq
  import fxp4s_pkg::*;
#(
  parameter int WIDTH = FXP4S_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic             overflow
);

  localparam int MAG = WIDTH - 1;
  localparam int CW  = (MAG > 1) ? $clog2(MAG) : 1;

  fxp4s_state_e     state_q, state_d;
  logic [MAG-1:0]   a_mag_q, a_mag_d;
  logic [MAG-1:0]   b_mag_q, b_mag_d;
  logic             sign_q, sign_d;
  logic [2*MAG-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_p_q, out_p_d;
  logic             ovf_q, ovf_d;

  logic [2*MAG-1:0] acc_nxt;
  logic             res_ovf;
  logic [MAG-1:0]   res_mag;

  fxp4s_mul_step #(
    .MAG (MAG),
    .CW  (CW)
  ) u_step (
    .acc     (acc_q),
    .a_mag   (a_mag_q),
    .b_bit   (b_mag_q[cnt_q]),
    .cnt     (cnt_q),
    .acc_nxt (acc_nxt)
  );

  // Result formatting works on the post-step accumulator so the last step and output register share an edge.
  always_comb begin
    res_ovf = |acc_nxt[2*MAG-1:MAG];
`ifdef FXP4S_MUL_SAT_EN
    res_mag = res_ovf ? {MAG{1'b1}} : acc_nxt[MAG-1:0];
`else
    res_mag = acc_nxt[MAG-1:0];
`endif
  end

  always_comb begin
    state_d = state_q;
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    sign_d  = sign_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_p_d = out_p_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_mag_d = in_a[MAG-1:0];
          b_mag_d = in_b[MAG-1:0];
          sign_d  = in_a[WIDTH-1] ^ in_b[WIDTH-1];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(MAG - 1)) begin
          out_p_d = {sign_q & (res_mag != '0), res_mag};
          ovf_d   = res_ovf;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      a_mag_q <= '0;
      b_mag_q <= '0;
      sign_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_p_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      sign_q  <= sign_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_p_q <= out_p_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_p     = out_p_q;
  assign overflow  = ovf_q;

endmodule
